// File: rtl/rr_selector.sv
// Per-input-port request selector: masks the route planner's adaptive request
// vector with output availability and grants one output at a time, using either
// fixed priority or round-robin priority. The grant is held until the scheduler
// accepts the transfer, the request/availability is withdrawn, or the optional
// hold timeout expires.
//
// Ports:
//   clk                        system clock
//   reset                      synchronous, active-high reset
//   request_vector_din         candidate outputs from the route planner
//   status_register_din        1 = output currently free
//   transfer_strobe_din        granted scheduler accepted the transfer
//   masked_request_vector_dout registered one-hot grant, 0 = none
//   grant_valid_dout           registered, high while a grant is held
//   grant_index_dout           registered binary index of the grant (0 when none)
//   timeout_dout               registered one-cycle pulse on forced release
module rr_selector #(
  parameter int unsigned NUM_OUT        = 4,
  parameter int unsigned RR_MODE        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  localparam int unsigned IDX_W         = $clog2(NUM_OUT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_OUT-1:0] request_vector_din,
  input  logic [NUM_OUT-1:0] status_register_din,
  input  logic               transfer_strobe_din,
  output logic [NUM_OUT-1:0] masked_request_vector_dout,
  output logic               grant_valid_dout,
  output logic [IDX_W-1:0]   grant_index_dout,
  output logic               timeout_dout
);

  // Counter is kept one bit wide when the timeout is disabled so it stays legal.
  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned TO_LAST_I  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]    hold_cnt;

  logic [NUM_OUT-1:0]  avail;
  int unsigned         rr_base;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [NUM_OUT-1:0]  win_onehot;
  logic                held_ok;
  logic [IDX_W-1:0]    next_ptr;

  assign avail = request_vector_din & status_register_din;

  // Winner search: scan starting at rr_ptr (round-robin) or at bit 0 (fixed).
  always_comb begin
    rr_base   = (RR_MODE != 0) ? 32'(rr_ptr) : 32'd0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (!win_found && avail[IDX_W'((rr_base + i) % NUM_OUT)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((rr_base + i) % NUM_OUT);
      end
    end
  end

  assign win_onehot = {{(NUM_OUT-1){1'b0}}, 1'b1} << win_idx;

  // The held grant stays legal only while both its request and status bits remain set.
  assign held_ok  = request_vector_din[grant_index_dout] & status_register_din[grant_index_dout];
  assign next_ptr = IDX_W'((32'(grant_index_dout) + 32'd1) % NUM_OUT);

  // Grant FSM: IDLE always lasts at least one cycle after a release, so a late
  // strobe can never be mistaken for acceptance of a fresh grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                      <= IDLE;
      rr_ptr                     <= '0;
      hold_cnt                   <= '0;
      masked_request_vector_dout <= '0;
      grant_valid_dout           <= 1'b0;
      grant_index_dout           <= '0;
      timeout_dout               <= 1'b0;
    end else begin
      timeout_dout <= 1'b0;
      if (state == IDLE) begin
        if (win_found) begin
          masked_request_vector_dout <= win_onehot;
          grant_valid_dout           <= 1'b1;
          grant_index_dout           <= win_idx;
          hold_cnt                   <= '0;
          state                      <= HOLD;
        end
      end else begin
        if (transfer_strobe_din) begin
          masked_request_vector_dout <= '0;
          grant_valid_dout           <= 1'b0;
          grant_index_dout           <= '0;
          rr_ptr                     <= next_ptr;
          state                      <= IDLE;
        end else if (!held_ok) begin
          masked_request_vector_dout <= '0;
          grant_valid_dout           <= 1'b0;
          grant_index_dout           <= '0;
          state                      <= IDLE;
        end else if (TIMEOUT_EN && (hold_cnt == TO_LAST)) begin
          masked_request_vector_dout <= '0;
          grant_valid_dout           <= 1'b0;
          grant_index_dout           <= '0;
          timeout_dout               <= 1'b1;
          rr_ptr                     <= next_ptr;
          state                      <= IDLE;
        end else if (hold_cnt != CNT_SAT) begin
          hold_cnt <= hold_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_selector.sv
// Self-checking bench for rr_selector: a round-robin instance with an 8-cycle
// hold timeout and a fixed-priority instance without timeout share one stimulus
// stream and are compared every cycle against a behavioural model.
module tb_rr_selector;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] st;
  logic       strobe;

  logic [3:0] vec_rr, vec_fp;
  logic       val_rr, val_fp;
  logic [1:0] idx_rr, idx_fp;
  logic       to_rr, to_fp;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state, index 0 = round-robin/timeout 8, 1 = fixed/no timeout.
  int p_rr[2] = '{1, 0};
  int p_to[2] = '{8, 0};
  int m_busy[2], m_g[2], m_ptr[2], m_cnt[2], m_to[2];

  rr_selector #(.NUM_OUT(4), .RR_MODE(1), .TIMEOUT_CYCLES(8)) dut_rr (
    .clk                        (clk),
    .reset                      (reset),
    .request_vector_din         (req),
    .status_register_din        (st),
    .transfer_strobe_din        (strobe),
    .masked_request_vector_dout (vec_rr),
    .grant_valid_dout           (val_rr),
    .grant_index_dout           (idx_rr),
    .timeout_dout               (to_rr)
  );

  rr_selector #(.NUM_OUT(4), .RR_MODE(0), .TIMEOUT_CYCLES(0)) dut_fp (
    .clk                        (clk),
    .reset                      (reset),
    .request_vector_din         (req),
    .status_register_din        (st),
    .transfer_strobe_din        (strobe),
    .masked_request_vector_dout (vec_fp),
    .grant_valid_dout           (val_fp),
    .grant_index_dout           (idx_fp),
    .timeout_dout               (to_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the reference model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_to[k] = 0;
      if (reset) begin
        m_busy[k] = 0; m_g[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
      end else if (m_busy[k] == 0) begin
        for (int i = 0; i < 4; i++) begin
          int c = (p_rr[k] != 0) ? (m_ptr[k] + i) % 4 : i;
          if (m_busy[k] == 0 && req[c] && st[c]) begin
            m_busy[k] = 1; m_g[k] = c; m_cnt[k] = 0;
          end
        end
      end else if (strobe) begin
        m_busy[k] = 0; m_ptr[k] = (m_g[k] + 1) % 4;
      end else if (!(req[m_g[k]] && st[m_g[k]])) begin
        m_busy[k] = 0;
      end else if (p_to[k] > 0 && m_cnt[k] == p_to[k] - 1) begin
        m_busy[k] = 0; m_to[k] = 1; m_ptr[k] = (m_g[k] + 1) % 4;
      end else begin
        m_cnt[k]++;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] ev;
    logic [1:0] ei;
    for (int k = 0; k < 2; k++) begin
      ev = (m_busy[k] != 0) ? 4'(1 << m_g[k]) : 4'd0;
      ei = (m_busy[k] != 0) ? 2'(m_g[k]) : 2'd0;
      if (k == 0) begin
        check("rr.vec", 32'(vec_rr), 32'(ev));
        check("rr.valid", 32'(val_rr), 32'(m_busy[k]));
        check("rr.index", 32'(idx_rr), 32'(ei));
        check("rr.timeout", 32'(to_rr), 32'(m_to[k]));
      end else begin
        check("fp.vec", 32'(vec_fp), 32'(ev));
        check("fp.valid", 32'(val_fp), 32'(m_busy[k]));
        check("fp.index", 32'(idx_fp), 32'(ei));
        check("fp.timeout", 32'(to_fp), 32'(m_to[k]));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; strobe = 1'b0;
    cycle();
    check("reset.rr_vec", 32'(vec_rr), 32'd0);
    check("reset.fp_vec", 32'(vec_fp), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req = 4'h0; st = 4'h0; strobe = 1'b0;
    do_reset();

    // Rotating grants with one IDLE cycle between; fixed priority always picks bit 0.
    req = 4'hF; st = 4'hF;
    for (int i = 0; i < 5; i++) begin
      strobe = 1'b0;
      cycle();
      check("rot.rr_grant", 32'(vec_rr), 32'(1 << (i % 4)));
      check("fix.fp_grant", 32'(vec_fp), 32'd1);
      check("fix.fp_index", 32'(idx_fp), 32'd0);
      strobe = 1'b1;
      cycle();
      check("rot.rr_idle", 32'(vec_rr), 32'd0);
    end

    // Reset while holding a grant drops it and returns the pointer to 0.
    strobe = 1'b0;
    cycle();
    check("rst_hold.rr_pre", 32'(vec_rr), 32'h2);
    reset = 1'b1;
    cycle();
    check("rst_hold.rr_vec", 32'(vec_rr), 32'd0);
    check("rst_hold.rr_valid", 32'(val_rr), 32'd0);
    reset = 1'b0;
    cycle();
    check("rst_hold.rr_regrant", 32'(vec_rr), 32'h1);

    // Status of the granted output falls: release without pointer movement, then regrant.
    do_reset();
    req = 4'b0100; st = 4'hF;
    cycle();
    check("wd.grant", 32'(vec_rr), 32'h4);
    st = 4'b1011;
    cycle();
    check("wd.release", 32'(vec_rr), 32'd0);
    cycle();
    check("wd.stay_idle", 32'(vec_rr), 32'd0);
    st = 4'hF;
    cycle();
    check("wd.regrant", 32'(vec_rr), 32'h4);
    st = 4'b1011;
    cycle();
    req = 4'hF; st = 4'hF;
    cycle();
    check("wd.ptr_kept", 32'(vec_rr), 32'h1);

    // Hold timeout: grant visible for 8 cycles, one-cycle pulse, next grant from index 2.
    do_reset();
    req = 4'b0010; st = 4'hF;
    cycle();
    for (int j = 0; j < 8; j++) begin
      check("to.held", 32'(vec_rr), 32'h2);
      check("to.no_pulse", 32'(to_rr), 32'd0);
      if (j < 7) cycle();
    end
    cycle();
    check("to.release", 32'(vec_rr), 32'd0);
    check("to.pulse", 32'(to_rr), 32'd1);
    check("to.fp_kept", 32'(vec_fp), 32'h2);
    req = 4'hF;
    cycle();
    check("to.pulse_end", 32'(to_rr), 32'd0);
    check("to.next", 32'(vec_rr), 32'h4);

    // Strobe coincident with status fall counts as acceptance.
    do_reset();
    req = 4'hF; st = 4'hF;
    cycle();
    check("acc.grant", 32'(vec_rr), 32'h1);
    strobe = 1'b1; st = 4'b1110;
    cycle();
    check("acc.release", 32'(vec_rr), 32'd0);
    check("acc.no_timeout", 32'(to_rr), 32'd0);
    strobe = 1'b0; st = 4'hF;
    cycle();
    check("acc.ptr_adv", 32'(vec_rr), 32'h2);

    // Randomised traffic with sticky inputs so long holds and timeouts occur.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) begin
        req = 4'($urandom);
        st  = 4'($urandom) | 4'($urandom);
      end
      strobe = ($urandom_range(9) == 0);
      reset  = ($urandom_range(99) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
